// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC / instruction-fetch stage.
// Imported by the fetch top level and the next-PC selector.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    EXEC = 2'b10,
    HALT = 2'b11
  } state_t;

  localparam logic [1:0] JMP_SEQ = 2'b00;
  localparam logic [1:0] JMP_ABS = 2'b01;
  localparam logic [1:0] JMP_REG = 2'b10;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  function automatic logic [31:0] br_off(
    input logic [15:0] imm
  );
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Next-PC selector: sequential, absolute jump, register jump, branch.
// Also flags jump encodings / targets that cannot be fetched.
module next_pc_sel
  import pc_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] PC,
  input  logic [25:0]       IR,
  input  logic [1:0]        Jump,
  input  logic              Branch,
  input  logic              Zero,
  input  logic [31:0]       JRTarget,
  output logic [ADDR_W-1:0] NextPC,
  output logic              BadTarget
);

  logic [31:0] pc32;
  logic [31:0] pc4;
  logic [31:0] nxt;
  logic        take_br;

  assign pc32    = 32'(PC);
  assign pc4     = pc32 + 32'd4;
  assign take_br = (Jump == JMP_SEQ) & Branch & Zero;

  // Branch target wraps silently mod 2^32, like pc4.
  always_comb begin
    nxt = pc4;
    unique case (1'b1)
      (Jump == JMP_REG): nxt = JRTarget;
      (Jump == JMP_ABS): nxt = {pc4[31:28], IR, 2'b00};
      take_br:           nxt = pc4 + br_off(IR[15:0]);
      default:           nxt = pc4;
    endcase
  end

  assign NextPC = ADDR_W'(nxt);

  assign BadTarget = (Jump == 2'b11) |
                     ((Jump == JMP_REG) &
                      (JRTarget[1:0] != 2'b00));

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, instruction register and fetch FSM.
// Drives the decoder with Op/Funct and holds it in reset outside EXEC.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              IMemReq,
  output logic [ADDR_W-1:0] IMemAddr,
  input  logic              IMemReady,
  input  logic [31:0]       IMemRdata,
  input  logic [1:0]        Jump,
  input  logic              Branch,
  input  logic              Zero,
  input  logic [31:0]       JRTarget,
  input  logic              Stall,
  output logic [31:0]       Instr,
  output logic [5:0]        Op,
  output logic [5:0]        Funct,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PCPlus4,
  output logic              InstrValid,
  output logic              CtlRst,
  output logic              Fault
);

  state_t            state;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       ir_q;
  logic              fault_q;
  logic [ADDR_W-1:0] next_pc;
  logic              bad_tgt;

  next_pc_sel #(
    .ADDR_W(ADDR_W)
  ) u_nps (
    .PC       (pc_q),
    .IR       (ir_q[25:0]),
    .Jump     (Jump),
    .Branch   (Branch),
    .Zero     (Zero),
    .JRTarget (JRTarget),
    .NextPC   (next_pc),
    .BadTarget(bad_tgt)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (IMemReady) begin
            ir_q  <= IMemRdata;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (!Stall) begin
            if (bad_tgt) begin
              fault_q <= 1'b1;
              state   <= HALT;
            end else begin
              pc_q  <= next_pc;
              state <= REQ;
            end
          end
        end
        HALT: state <= HALT;
      endcase
    end
  end

  // Outputs decode straight off the state register, so they
  // follow an asynchronous reset without waiting for a clock.
  assign IMemReq    = (state == REQ);
  assign IMemAddr   = {pc_q[ADDR_W-1:2], 2'b00};
  assign InstrValid = (state == EXEC);
  assign CtlRst     = ~InstrValid;

  assign Instr   = ir_q;
  assign Op      = ir_q[31:26];
  assign Funct   = ir_q[5:0];
  assign PC      = pc_q;
  assign PCPlus4 = pc_q + ADDR_W'(4);
  assign Fault   = fault_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit.
// Each task drives one scenario and checks its own results.
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady = 1'b0;
  logic [31:0] IMemRdata = '0;
  logic [1:0]  Jump = 2'b00;
  logic        Branch = 1'b0;
  logic        Zero = 1'b0;
  logic [31:0] JRTarget = '0;
  logic        Stall = 1'b0;
  logic [31:0] Instr;
  logic [5:0]  Op;
  logic [5:0]  Funct;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        InstrValid;
  logic        CtlRst;
  logic        Fault;

  int n_chk = 0;
  int n_fail = 0;

  pc_fetch_unit dut (
    .CLK       (CLK),
    .RST       (RST),
    .IMemReq   (IMemReq),
    .IMemAddr  (IMemAddr),
    .IMemReady (IMemReady),
    .IMemRdata (IMemRdata),
    .Jump      (Jump),
    .Branch    (Branch),
    .Zero      (Zero),
    .JRTarget  (JRTarget),
    .Stall     (Stall),
    .Instr     (Instr),
    .Op        (Op),
    .Funct     (Funct),
    .PC        (PC),
    .PCPlus4   (PCPlus4),
    .InstrValid(InstrValid),
    .CtlRst    (CtlRst),
    .Fault     (Fault)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Zero-wait fetch from REQ into EXEC.
  task automatic fetch(input logic [31:0] w);
    IMemReady = 1'b1;
    IMemRdata = w;
    tick();
    IMemReady = 1'b0;
    IMemRdata = '0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    tick();
    tick();
    n_chk++;
    if (IMemReq !== 1'b0 || InstrValid !== 1'b0 || CtlRst !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ctl: req=%b iv=%b crst=%b want 0 0 1", IMemReq, InstrValid, CtlRst);
    end
    n_chk++;
    if (PC !== 32'h0 || Instr !== 32'h0 || Fault !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_regs: pc=%h ir=%h f=%b want 0 0 0", PC, Instr, Fault);
    end
  endtask

  task automatic test_zero_wait();
    IMemReady = 1'b1;
    IMemRdata = 32'h2008_0005;
    RST = 1'b1;
    n_chk++;
    if (IMemReq !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_req: got %b want 0", IMemReq);
    end
    tick();
    n_chk++;
    if (IMemReq !== 1'b1 || IMemAddr !== 32'h0) begin
      n_fail++;
      $display("FAIL req0: req=%b addr=%h want 1 0", IMemReq, IMemAddr);
    end
    tick();
    n_chk++;
    if (InstrValid !== 1'b1 || CtlRst !== 1'b0 || IMemReq !== 1'b0) begin
      n_fail++;
      $display("FAIL exec0: iv=%b crst=%b req=%b want 1 0 0", InstrValid, CtlRst, IMemReq);
    end
    n_chk++;
    if (Instr !== 32'h2008_0005 || Op !== 6'h08 || Funct !== 6'h05 || PCPlus4 !== 32'h4) begin
      n_fail++;
      $display("FAIL ir0: ir=%h op=%h fn=%h p4=%h want 20080005 08 05 4", Instr, Op, Funct, PCPlus4);
    end
    IMemReady = 1'b0;
    tick();
    n_chk++;
    if (IMemReq !== 1'b1 || IMemAddr !== 32'h4) begin
      n_fail++;
      $display("FAIL req4: req=%b addr=%h want 1 4", IMemReq, IMemAddr);
    end
  endtask

  task automatic test_wait_states();
    int iv_cnt = 0;
    IMemRdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (IMemReq !== 1'b1 || IMemAddr !== 32'h4 || InstrValid !== 1'b0) begin
        n_fail++;
        $display("FAIL wait%0d: req=%b addr=%h iv=%b want 1 4 0", i, IMemReq, IMemAddr, InstrValid);
      end
    end
    IMemReady = 1'b1;
    IMemRdata = 32'h0000_0020;
    tick();
    iv_cnt += int'(InstrValid);
    IMemRdata = 32'h1111_1111;
    n_chk++;
    if (Instr !== 32'h0000_0020) begin
      n_fail++;
      $display("FAIL wait_ir: got %h want 00000020", Instr);
    end
    IMemReady = 1'b0;
    tick();
    iv_cnt += int'(InstrValid);
    n_chk++;
    if (iv_cnt != 1 || Instr !== 32'h0000_0020 || IMemAddr !== 32'h8) begin
      n_fail++;
      $display("FAIL wait_once: ivc=%0d ir=%h addr=%h want 1 00000020 8", iv_cnt, Instr, IMemAddr);
    end
    fetch(32'h0000_0020);
  endtask

  task automatic test_branch();
    Jump = 2'b10;
    JRTarget = 32'h40;
    tick();
    Jump = 2'b00;
    n_chk++;
    if (IMemAddr !== 32'h40) begin
      n_fail++;
      $display("FAIL jr40: got %h want 40", IMemAddr);
    end
    fetch(32'h1000_FFFF);
    Branch = 1'b1;
    Zero = 1'b1;
    tick();
    n_chk++;
    if (IMemReq !== 1'b1 || IMemAddr !== 32'h40) begin
      n_fail++;
      $display("FAIL beq_taken: req=%b addr=%h want 1 40", IMemReq, IMemAddr);
    end
    fetch(32'h1000_FFFF);
    Zero = 1'b0;
    tick();
    Branch = 1'b0;
    n_chk++;
    if (IMemAddr !== 32'h44) begin
      n_fail++;
      $display("FAIL beq_not: got %h want 44", IMemAddr);
    end
  endtask

  task automatic test_jump();
    fetch(32'h0);
    Jump = 2'b10;
    JRTarget = 32'h1000_0000;
    tick();
    fetch(32'h0800_0010);
    Jump = 2'b01;
    tick();
    n_chk++;
    if (IMemAddr !== 32'h1000_0040) begin
      n_fail++;
      $display("FAIL j_abs: got %h want 10000040", IMemAddr);
    end
    fetch(32'h0000_0008);
    Jump = 2'b10;
    JRTarget = 32'h80;
    tick();
    Jump = 2'b00;
    n_chk++;
    if (IMemAddr !== 32'h80) begin
      n_fail++;
      $display("FAIL jr80: got %h want 80", IMemAddr);
    end
  endtask

  task automatic test_fault();
    fetch(32'h0000_0008);
    Jump = 2'b10;
    JRTarget = 32'h82;
    tick();
    Jump = 2'b00;
    n_chk++;
    if (Fault !== 1'b1 || IMemReq !== 1'b0 || CtlRst !== 1'b1 || PC !== 32'h80) begin
      n_fail++;
      $display("FAIL jr_fault: f=%b req=%b crst=%b pc=%h want 1 0 1 80", Fault, IMemReq, CtlRst, PC);
    end
    IMemReady = 1'b1;
    tick();
    tick();
    IMemReady = 1'b0;
    n_chk++;
    if (Fault !== 1'b1 || IMemReq !== 1'b0 || InstrValid !== 1'b0 || PC !== 32'h80) begin
      n_fail++;
      $display("FAIL halt_hold: f=%b req=%b iv=%b pc=%h want 1 0 0 80", Fault, IMemReq, InstrValid, PC);
    end
    RST = 1'b0;
    #1;
    n_chk++;
    if (PC !== 32'h0 || Fault !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_rst: pc=%h f=%b want 0 0", PC, Fault);
    end
    tick();
    RST = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    fetch(32'h0);
    Jump = 2'b10;
    JRTarget = 32'hFFFF_FFFC;
    tick();
    Jump = 2'b00;
    n_chk++;
    if (IMemAddr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_addr: got %h want fffffffc", IMemAddr);
    end
    fetch(32'h0);
    n_chk++;
    if (PCPlus4 !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_p4: got %h want 0", PCPlus4);
    end
    tick();
    n_chk++;
    if (IMemReq !== 1'b1 || IMemAddr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_next: req=%b addr=%h want 1 0", IMemReq, IMemAddr);
    end
  endtask

  task automatic test_stall();
    fetch(32'h0000_0020);
    Stall = 1'b1;
    Jump = 2'b10;
    JRTarget = 32'h100;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_chk++;
      if (InstrValid !== 1'b1 || PC !== 32'h0 || IMemReq !== 1'b0) begin
        n_fail++;
        $display("FAIL stall%0d: iv=%b pc=%h req=%b want 1 0 0", i, InstrValid, PC, IMemReq);
      end
    end
    Stall = 1'b0;
    tick();
    Jump = 2'b00;
    n_chk++;
    if (IMemReq !== 1'b1 || IMemAddr !== 32'h100) begin
      n_fail++;
      $display("FAIL stall_rel: req=%b addr=%h want 1 100", IMemReq, IMemAddr);
    end
  endtask

  task automatic test_rst_mid_req();
    IMemReady = 1'b1;
    IMemRdata = 32'hCAFE_F00D;
    RST = 1'b0;
    #1;
    n_chk++;
    if (IMemReq !== 1'b0 || CtlRst !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_req: req=%b crst=%b want 0 1", IMemReq, CtlRst);
    end
    tick();
    n_chk++;
    if (Instr !== 32'h0 || InstrValid !== 1'b0 || PC !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_ign: ir=%h iv=%b pc=%h want 0 0 0", Instr, InstrValid, PC);
    end
    IMemReady = 1'b0;
    RST = 1'b1;
    tick();
  endtask

  task automatic test_jump11();
    fetch(32'h0);
    Jump = 2'b11;
    tick();
    Jump = 2'b00;
    n_chk++;
    if (Fault !== 1'b1 || IMemReq !== 1'b0 || PC !== 32'h0) begin
      n_fail++;
      $display("FAIL j11_fault: f=%b req=%b pc=%h want 1 0 0", Fault, IMemReq, PC);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_branch();
    test_jump();
    test_fault();
    test_wrap();
    test_stall();
    test_rst_mid_req();
    test_jump11();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
